// File: rtl/segdisplay_mux.sv
// ---------------------------------------------------------------------------
// segdisplay_mux
//   Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment bus.
//   Each digit is lit for DWELL scan-clock cycles, scanning from the leftmost
//   digit (NUM_DIGITS-1) down to digit 0. Display data enters through a shadow
//   buffer on a load strobe and is copied into the active buffer only on the
//   tick that drives digit 0, so a frame never mixes old and new data.
//
// Parameters
//   NUM_DIGITS  digits scanned (2..8)
//   DWELL       segclk cycles each digit stays lit (>= 1)
//   ACTIVE_LOW  1 = seg/dp/an active-low, 0 = active-high
//
// Ports
//   segclk          scan clock
//   clr_n           asynchronous active-low reset
//   load            one-cycle strobe capturing data_in/dp_in/blank_in/lz_en
//   data_in         nibble i drives digit i (digit NUM_DIGITS-1 is leftmost)
//   dp_in           decimal point enable per digit
//   blank_in        forces a digit dark
//   lz_en           leading-zero suppression enable
//   seg             segments {g,f,e,d,c,b,a}
//   dp              decimal point
//   an              digit anode enables
//   update_pending  shadow holds data not yet shown
//   frame_done      one-cycle pulse with the tick that drives digit 0
// ---------------------------------------------------------------------------
module segdisplay_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL      = 1,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    segclk,
   input  logic                    clr_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    update_pending,
   output logic                    frame_done
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int PTR_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(NUM_DIGITS - 1);
   localparam logic             OFF      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic             ON       = ~OFF;

   // Active-low segment pattern, bits {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         default: pat = 7'b0001110;
      endcase
      return pat;
   endfunction

   // Map the active-low pattern onto the configured pin polarity.
   function automatic logic [6:0] seg_polarity(input logic [6:0] pat);
      return (ACTIVE_LOW != 0) ? pat : ~pat;
   endfunction

   logic [CNT_W-1:0]        cnt;
   logic [PTR_W-1:0]        ptr;

   logic [4*NUM_DIGITS-1:0] sh_data;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic                    sh_lz;

   logic [4*NUM_DIGITS-1:0] act_data;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic [NUM_DIGITS-1:0]   act_blank;
   logic                    act_lz;

   logic                    tick;
   logic                    swap;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_dark;
   logic [NUM_DIGITS-1:0]   an_sel;

   assign tick = (cnt == CNT_LAST);
   assign swap = tick && (ptr == '0);

   // Leading-zero mask: a digit is suppressed while every nibble from the
   // leftmost digit down to it is zero. Digit 0 is never in the mask.
   always_comb begin
      lz_mask  = '0;
      zero_run = act_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run   = zero_run && (act_data[4*i +: 4] == 4'h0);
         lz_mask[i] = zero_run;
      end
   end

   // Select the digit under the scan pointer.
   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_dark = 1'b0;
      an_sel   = {NUM_DIGITS{OFF}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr == PTR_W'(i)) begin
            cur_nib   = act_data[4*i +: 4];
            cur_dp    = act_dp[i];
            cur_dark  = act_blank[i] || lz_mask[i];
            an_sel[i] = ON;
         end
      end
   end

   // ---- scan / buffer / output register stage ----
   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         cnt            <= '0;
         ptr            <= PTR_TOP;
         seg            <= {7{OFF}};
         dp             <= OFF;
         an             <= {NUM_DIGITS{OFF}};
         frame_done     <= 1'b0;
         update_pending <= 1'b0;
         sh_data        <= '0;
         sh_dp          <= '0;
         sh_blank       <= '0;
         sh_lz          <= 1'b0;
         act_data       <= '0;
         act_dp         <= '0;
         act_blank      <= '0;
         act_lz         <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (tick) begin
            cnt <= '0;
            if (cur_dark) begin
               // Blanked slot keeps its timing but lights nothing.
               seg <= {7{OFF}};
               dp  <= OFF;
               an  <= {NUM_DIGITS{OFF}};
            end else begin
               seg <= seg_polarity(hex_decode(cur_nib));
               dp  <= cur_dp ? ON : OFF;
               an  <= an_sel;
            end
            ptr <= (ptr == '0) ? PTR_TOP : ptr - 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Digit 0 above still used the old active data; the new frame
         // starts from the shadow contents held before this edge.
         if (swap) begin
            frame_done <= 1'b1;
            act_data   <= sh_data;
            act_dp     <= sh_dp;
            act_blank  <= sh_blank;
            act_lz     <= sh_lz;
         end

         if (load) begin
            sh_data  <= data_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
            sh_lz    <= lz_en;
         end

         // A load landing on the swap edge keeps the flag set for its data.
         if (load) begin
            update_pending <= 1'b1;
         end else if (swap) begin
            update_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_segdisplay_mux.sv
// ---------------------------------------------------------------------------
// tb_segdisplay_mux
//   Drives two segdisplay_mux instances (DWELL=1 and DWELL=3, four digits,
//   active-low) from the same stimulus. A reference model computes, for every
//   clock edge, what each display should show from the scan timing
//   (edge count modulo DWELL, tick count modulo digit count), the buffered
//   frame data and the leading-zero rule; expected outputs are queued and a
//   monitor compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_segdisplay_mux;

   localparam int N = 4;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic       pend;
      logic       fd;
   } obs_t;

   localparam obs_t OFF_OBS = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, pend: 1'b0, fd: 1'b0};

   localparam logic [6:0] DEC [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic          clk   = 1'b1;
   logic          clr_n = 1'b1;
   logic          load;
   logic [15:0]   data_in;
   logic [3:0]    dp_in;
   logic [3:0]    blank_in;
   logic          lz_en;

   logic [6:0]    seg1, seg3;
   logic          dp1, dp3;
   logic [3:0]    an1, an3;
   logic          pend1, pend3;
   logic          fd1, fd3;

   obs_t          o0, o1;
   assign o0 = {seg1, dp1, an1, pend1, fd1};
   assign o1 = {seg3, dp3, an3, pend3, fd3};

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   segdisplay_mux #(.NUM_DIGITS(N), .DWELL(1), .ACTIVE_LOW(1)) u_dut1 (
      .segclk(clk), .clr_n(clr_n), .load(load), .data_in(data_in),
      .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
      .seg(seg1), .dp(dp1), .an(an1),
      .update_pending(pend1), .frame_done(fd1));

   segdisplay_mux #(.NUM_DIGITS(N), .DWELL(3), .ACTIVE_LOW(1)) u_dut3 (
      .segclk(clk), .clr_n(clr_n), .load(load), .data_in(data_in),
      .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
      .seg(seg3), .dp(dp3), .an(an3),
      .update_pending(pend3), .frame_done(fd3));

   // ---------------- reference model ----------------
   int          kc [2];
   int          tc [2];
   logic [15:0] a_data [2];
   logic [3:0]  a_dp [2];
   logic [3:0]  a_blank [2];
   logic        a_lz [2];
   logic [15:0] s_data [2];
   logic [3:0]  s_dp [2];
   logic [3:0]  s_blank [2];
   logic        s_lz [2];
   logic        m_pend [2];
   logic [6:0]  h_seg [2];
   logic        h_dp [2];
   logic [3:0]  h_an [2];

   obs_t q0 [$];
   obs_t q1 [$];

   task automatic model_reset(input int i);
      kc[i] = 0;      tc[i] = 0;
      a_data[i] = '0; a_dp[i] = '0; a_blank[i] = '0; a_lz[i] = 1'b0;
      s_data[i] = '0; s_dp[i] = '0; s_blank[i] = '0; s_lz[i] = 1'b0;
      m_pend[i] = 1'b0;
      h_seg[i] = 7'h7F; h_dp[i] = 1'b1; h_an[i] = 4'hF;
   endtask

   task automatic model_step(input int i, input int dw, output obs_t e);
      int   d;
      int   hi;
      logic fd;
      logic dark;
      logic [3:0] nib;
      fd = 1'b0;
      if ((kc[i] % dw) == dw - 1) begin
         d  = (N - 1) - (tc[i] % N);
         hi = -1;
         for (int j = N - 1; j >= 0; j--)
            if (hi < 0 && a_data[i][4*j +: 4] != 4'h0) hi = j;
         nib  = a_data[i][4*d +: 4];
         dark = a_blank[i][d] || (a_lz[i] && d > 0 && d > hi);
         if (dark) begin
            h_seg[i] = 7'h7F; h_dp[i] = 1'b1; h_an[i] = 4'hF;
         end else begin
            h_seg[i] = DEC[nib];
            h_dp[i]  = ~a_dp[i][d];
            h_an[i]  = 4'hF & ~(4'b0001 << d);
         end
         tc[i]++;
         if (d == 0) begin
            fd = 1'b1;
            a_data[i] = s_data[i]; a_dp[i] = s_dp[i];
            a_blank[i] = s_blank[i]; a_lz[i] = s_lz[i];
            m_pend[i] = 1'b0;
         end
      end
      kc[i]++;
      if (load) begin
         s_data[i] = data_in; s_dp[i] = dp_in;
         s_blank[i] = blank_in; s_lz[i] = lz_en;
         m_pend[i] = 1'b1;
      end
      e.seg = h_seg[i]; e.dp = h_dp[i]; e.an = h_an[i];
      e.pend = m_pend[i]; e.fd = fd;
   endtask

   always @(posedge clk or negedge clr_n) begin
      obs_t e;
      if (!clr_n) begin
         for (int i = 0; i < 2; i++) model_reset(i);
         q0.delete(); q1.delete();
         q0.push_back(OFF_OBS); q1.push_back(OFF_OBS);
      end else begin
         model_step(0, 1, e); q0.push_back(e);
         model_step(1, 3, e); q1.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got seg=%b dp=%b an=%b pend=%b fd=%b, want seg=%b dp=%b an=%b pend=%b fd=%b",
                  name, $time, got.seg, got.dp, got.an, got.pend, got.fd,
                  exp.seg, exp.dp, exp.an, exp.pend, exp.fd);
      end
   endtask

   always @(negedge clk or negedge clr_n) begin
      obs_t e;
      if (clk) begin
         // Reset asserted while the clock is high: outputs must already be off.
         #1;
         check("async_rst_dwell1", o0, OFF_OBS);
         check("async_rst_dwell3", o1, OFF_OBS);
      end else begin
         if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_dwell1 t=%0t: no expected entry queued", $time);
         end else begin
            e = q0.pop_front();
            check("out_dwell1", o0, e);
         end
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_dwell3 t=%0t: no expected entry queued", $time);
         end else begin
            e = q1.pop_front();
            check("out_dwell3", o1, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                          input logic [3:0] b, input logic lz);
      load = 1'b1; data_in = d; dp_in = p; blank_in = b; lz_en = lz;
      cycles(1);
      load = 1'b0;
   endtask

   // Wait until the next edge of the DWELL=1 display drives digit dgt.
   task automatic wait_digit(input int dgt);
      for (int g = 0; g < N && ((N - 1) - (tc[0] % N)) != dgt; g++) cycles(1);
   endtask

   initial begin
      load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
      #1 clr_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 clr_n = 1'b1;

      // Free-running scan of zeros.
      cycles(12);

      // Mid-frame load: current frame unchanged, next frame shows 1 2 A F.
      wait_digit(2);
      do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
      cycles(14);

      // Leading-zero suppression.
      do_load(16'h0005, 4'b1111, 4'b0000, 1'b1);
      cycles(14);
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
      cycles(14);
      do_load(16'h0300, 4'b0101, 4'b0010, 1'b1);
      cycles(14);

      // Load coincident with the digit-0 swap.
      wait_digit(2);
      do_load(16'h3C4D, 4'b0010, 4'b0000, 1'b0);
      wait_digit(0);
      do_load(16'h9876, 4'b1000, 4'b0000, 1'b0);
      cycles(14);

      // Randomized loads at random spacing.
      for (int r = 0; r < 60; r++) begin
         logic [15:0] d;
         for (int j = 0; j < 4; j++)
            d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         do_load(d, 4'($urandom), 4'($urandom & $urandom & $urandom),
                 1'($urandom));
         cycles($urandom_range(0, 7));
      end
      cycles(14);

      // Reset pulse mid-dwell, released before the next edge.
      @(posedge clk);
      #2 clr_n = 1'b0;
      #2 clr_n = 1'b1;
      cycles(16);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/segdisplay_mux.md
Name: segdisplay_mux

Overview:
- Parametrised successor to the fixed four-letter 7-segment scanner.
- Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus. Supports a per-digit decimal point, per-digit blanking, leading-zero suppression and a programmable dwell time per digit.
- Display data is written through a double-buffered load strobe and applied only at frame boundaries, so a frame never shows a mix of old and new data.
- Sits between game/score logic and the board's 7-segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- DWELL, 1, segclk cycles each digit stays lit; legal range >= 1.
- ACTIVE_LOW, 1, 1 = seg/dp/an are driven active-low; 0 = active-high.

Ports:
- segclk  in  1  scan clock.
- clr_n  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle strobe that captures data_in, dp_in, blank_in and lz_en into the shadow registers.
- data_in  in  4*NUM_DIGITS  hex nibble per digit; nibble i is digit i; digit NUM_DIGITS-1 is leftmost.
- dp_in  in  NUM_DIGITS  decimal point enable per digit.
- blank_in  in  NUM_DIGITS  forces digit dark.
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  digit anode enables.
- update_pending  out  1  shadow holds data not yet displayed.
- frame_done  out  1  one-cycle pulse when the last digit of a frame is driven.

Behaviour:
- Reset (clr_n low, asynchronous):
  - seg, dp and all an bits go to the OFF level (all 1 when ACTIVE_LOW=1).
  - Active and shadow registers clear to 0 / unblanked / lz off.
  - update_pending=0, frame_done=0, scan pointer=NUM_DIGITS-1, dwell counter=0.
- Dwell counter:
  - Increments every segclk cycle.
  - A "tick" occurs when the counter equals DWELL-1; the counter wraps to 0 on the tick.
  - With DWELL=1 every cycle is a tick.
- On each tick, registered outputs drive the digit at the scan pointer:
  - an has exactly that bit ON, all others OFF.
  - seg = decode(active nibble); dp = active dp bit.
  - Pointer then decrements, wrapping from 0 back to NUM_DIGITS-1. Scan order is left to right.
- Output latency:
  - The first tick after reset release drives digit NUM_DIGITS-1.
  - Outputs hold their values between ticks.
- Hex decode (ACTIVE_LOW=1 encoding, bits g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - With ACTIVE_LOW=0, every output bit is inverted.
- Blanked digit:
  - Applies when blank_in is set, or when the digit is suppressed as a leading zero.
  - seg and dp go OFF, and the an bit for that slot stays OFF for its whole dwell. Timing slot is preserved and the scan does not skip.
- Leading-zero suppression (lz_en=1):
  - Digits from NUM_DIGITS-1 downward whose nibble is 0 are suppressed until the first non-zero nibble.
  - Digit 0 is never suppressed.
  - The dp bit of a suppressed digit is also dark.
- Load / shadow buffer:
  - load=1 captures all inputs into the shadow registers and sets update_pending.
  - Repeated loads before a swap: last one wins.
- Swap:
  - Happens on the tick that drives digit 0.
  - Active registers take the shadow contents and update_pending clears. The next frame uses the new data.
  - Digit 0 on that tick still shows the old data.
- frame_done: asserted for exactly one cycle, coincident with the tick driving digit 0.
- load coincident with swap:
  - The swap takes the shadow value held before this edge.
  - The new load data lands in the shadow and update_pending stays 1.
- Reset mid-frame: immediate return to the reset state; no partial swap persists.

Test Plan:
- Reset then release, DWELL=1, no load → an sequence 0111, 1011, 1101, 1110 repeating; seg=1000000 on every digit; frame_done high on each an=1110 cycle.
- load data_in=16'h12AF at mid-frame → current frame unchanged; next frame seg = 1111001, 0100100, 0001000, 0001110; update_pending high from load until the digit-0 tick.
- data_in=16'h0005, lz_en=1 → digits 3..1 show an all OFF with seg=1111111; digit 0 shows 0010010. With data_in=16'h0000, digit 0 shows 1000000.
- DWELL=3 → each an value held for exactly 3 cycles; frame_done period is 12 cycles.
- load asserted on the same edge as the digit-0 tick with a different pending value → following frame shows the previously pending data; update_pending stays 1; the frame after that shows the newest data.
- clr_n pulsed low mid-dwell → outputs go OFF asynchronously without waiting for an edge; after release, first tick drives digit 3 with data 0.
